audio_dac_serializer: RTL and testbench



---
 rtl/audio_dac_serializer_if.sv | 41 ++++
 rtl/audio_dac_serializer.sv | 169 ++++++++++++++++
 tb/tb_audio_dac_serializer.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_dac_serializer_if.sv
// ----------------------------------------------------------------------------
// audio_dac_serializer_if
//
// Stereo PCM frame stream from the tone generators/mixer into the I2S
// serializer.
//
// Signals
//   left_in     [31:0]  left sample, two's complement
//   right_in    [31:0]  right sample, two's complement
//   frame_valid         left_in/right_in carry a frame
//   frame_ready         serializer FIFO can accept a frame
//
// Handshake: a frame is transferred on every CLOCK_50 edge where
// frame_valid && frame_ready are both high. While frame_valid is high and
// frame_ready is low, the master holds left_in/right_in stable and keeps
// frame_valid asserted. frame_ready does not depend on frame_valid.
//
// Modports
//   master  frame source (drives data and valid, observes ready)
//   slave   serializer   (observes data and valid, drives ready)
// ----------------------------------------------------------------------------
interface audio_dac_serializer_if;
    logic [31:0] left_in;
    logic [31:0] right_in;
    logic        frame_valid;
    logic        frame_ready;

    modport master (
        output left_in,
        output right_in,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  left_in,
        input  right_in,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/audio_dac_serializer.sv
// ----------------------------------------------------------------------------
// audio_dac_serializer
//
// Buffers stereo 32-bit PCM frames in a small FIFO and plays them out as an
// I2S bus master towards the codec DAC. BCLK, LRCK and serial data are all
// generated from CLOCK_50. When a frame slot starts with the FIFO empty, a
// silent (all-zero) frame is played and underflow pulses for one cycle.
//
// Parameters
//   BCLK_DIV    CLOCK_50 cycles per BCLK half-period (>= 2)
//   FIFO_DEPTH  frame FIFO entries (power of two, >= 2)
//
// Ports
//   CLOCK_50     in   system clock
//   reset        in   synchronous, active-high
//   pcm          slave side of the frame stream (left/right/valid/ready)
//   fifo_level   out  frames currently buffered
//   underflow    out  one-cycle pulse: frame slot started with FIFO empty
//   AUD_BCLK     out  I2S bit clock
//   AUD_DACLRCK  out  0 = left channel, 1 = right channel
//   AUD_DACDAT   out  serial data, MSB first, one BCLK after the LRCK edge
// ----------------------------------------------------------------------------
module audio_dac_serializer #(
    parameter int BCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    audio_dac_serializer_if.slave        pcm,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         underflow,
    output logic                         AUD_BCLK,
    output logic                         AUD_DACLRCK,
    output logic                         AUD_DACDAT
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int DIV_W = $clog2(BCLK_DIV);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;          // current slot, 0..63
    logic [63:0]      frame_reg;        // frame being serialized, {left,right}
    logic             saved_lsb;        // bit 0 of the frame that just ended
    logic [63:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic             bclk_edge;        // div_cnt wraps, BCLK toggles
    logic             fall_event;       // BCLK about to go 1 -> 0
    logic [5:0]       bit_cnt_next;
    logic             slot0_entry;      // fall event that starts a new frame
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [5:0]       slot_bit;         // frame_reg bit driven in the new slot
    logic             dat_next;
    logic [63:0]      frame_next;
    logic [LVL_W-1:0] level_next;

    always_comb begin
        bclk_edge    = (div_cnt == DIV_W'(BCLK_DIV - 1));
        fall_event   = bclk_edge && AUD_BCLK;
        bit_cnt_next = bit_cnt + 6'd1;
        slot0_entry  = fall_event && (bit_cnt_next == 6'd0);

        fifo_empty   = (fifo_level == '0);
        fifo_full    = (fifo_level == LVL_W'(FIFO_DEPTH));

        // Ready comes only from the registered level, so a push can never
        // be accepted into a full FIFO even when a pop happens on the same
        // edge.
        push         = pcm.frame_valid && !fifo_full;
        // An empty FIFO at slot 0 is an underflow, not a pop; a push on the
        // same edge is simply stored.
        pop          = slot0_entry && !fifo_empty;
    end

    assign pcm.frame_ready = !fifo_full;

    // I2S one-bit delay: slot s (1..63) carries frame_reg[64-s], which is
    // the 6-bit two's complement of s. Slot 0 carries the previous frame's
    // bit 0, which frame_reg no longer holds after the slot-0 load.
    always_comb begin
        slot_bit   = 6'd0 - bit_cnt_next;
        dat_next   = slot0_entry ? saved_lsb : frame_reg[slot_bit];
        frame_next = fifo_empty ? 64'h0 : mem[rd_ptr];
    end

    always_comb begin
        level_next = fifo_level;
        case ({push, pop})
            2'b10:   level_next = fifo_level + LVL_W'(1);
            2'b01:   level_next = fifo_level - LVL_W'(1);
            default: level_next = fifo_level;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame storage (no reset needed: pointers define what is valid)
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!reset && push) begin
            mem[wr_ptr] <= {pcm.left_in, pcm.right_in};
        end
    end

    // ------------------------------------------------------------------
    // BCLK divider, slot counter, pins and FIFO pointers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div_cnt     <= '0;
            AUD_BCLK    <= 1'b0;
            bit_cnt     <= 6'd63;   // first fall event enters slot 0
            AUD_DACLRCK <= 1'b1;
            AUD_DACDAT  <= 1'b0;
            underflow   <= 1'b0;
            frame_reg   <= 64'h0;
            saved_lsb   <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
        end else begin
            underflow <= 1'b0;

            if (bclk_edge) begin
                div_cnt  <= '0;
                AUD_BCLK <= ~AUD_BCLK;
            end else begin
                div_cnt  <= div_cnt + DIV_W'(1);
            end

            // All pins change together with the BCLK falling edge so the
            // codec sees them stable over the whole high phase.
            if (fall_event) begin
                bit_cnt     <= bit_cnt_next;
                AUD_DACLRCK <= bit_cnt_next[5];
                AUD_DACDAT  <= dat_next;
                // Entering the last slot: remember bit 0 for the coming
                // slot 0, since frame_reg is overwritten there.
                if (bit_cnt_next == 6'd63) begin
                    saved_lsb <= frame_reg[0];
                end
            end

            if (slot0_entry) begin
                frame_reg <= frame_next;
                underflow <= fifo_empty;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level <= level_next;
        end
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
module tb_audio_dac_serializer;

    // ---------------------------------------------------------------
    // Clock / reset block
    // ---------------------------------------------------------------
    logic CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic        rst_drv   = 1'b1;
    logic        valid_drv = 1'b0;
    logic [31:0] left_drv  = '0;
    logic [31:0] right_drv = '0;

    localparam int DEPTH = 4;

    // Two instances share the stimulus: BCLK_DIV=8 and BCLK_DIV=2.
    audio_dac_serializer_if pcm8 ();
    audio_dac_serializer_if pcm2 ();
    assign pcm8.left_in     = left_drv;
    assign pcm8.right_in    = right_drv;
    assign pcm8.frame_valid = valid_drv;
    assign pcm2.left_in     = left_drv;
    assign pcm2.right_in    = right_drv;
    assign pcm2.frame_valid = valid_drv;

    logic [2:0] lvl8, lvl2;
    logic uf8, b8, lr8, d8, uf2, b2, lr2, d2;

    audio_dac_serializer #(.BCLK_DIV(8), .FIFO_DEPTH(DEPTH)) dut8 (
        .CLOCK_50(CLOCK_50), .reset(rst_drv), .pcm(pcm8),
        .fifo_level(lvl8), .underflow(uf8), .AUD_BCLK(b8),
        .AUD_DACLRCK(lr8), .AUD_DACDAT(d8)
    );

    audio_dac_serializer #(.BCLK_DIV(2), .FIFO_DEPTH(DEPTH)) dut2 (
        .CLOCK_50(CLOCK_50), .reset(rst_drv), .pcm(pcm2),
        .fifo_level(lvl2), .underflow(uf2), .AUD_BCLK(b2),
        .AUD_DACLRCK(lr2), .AUD_DACDAT(d2)
    );

    // ---------------------------------------------------------------
    // Scoreboard state
    // ---------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    bit          dsel = 1'b0;     // 0: BCLK_DIV=8 instance, 1: BCLK_DIV=2
    int          n    = 0;        // edges since reset release
    logic [63:0] mq[$];           // reference FIFO contents
    logic [63:0] cur  = '0;       // frame currently on the wire
    bit          m_bclk = 1'b0, m_lrck = 1'b1, m_dat = 1'b0;
    bit          last_pushed = 1'b0;
    bit          fell = 1'b0;
    int          fall_slot = 0;
    int          fall_cnt = 0;

    logic [63:0] exp_q[$];        // frames loaded, awaiting decode from pins
    logic [63:0] seen_q[$];       // frames decoded from pins
    logic [63:0] dec = '0;
    bit          have = 1'b0;
    int          uf_q[$];         // edges where underflow was seen
    int          ones = 0;        // cycles with AUD_DACDAT=1

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at n=%0d sel=%0d: got %h, want %h", name, n, dsel, got, want);
        end
    endtask

    // {fifo_level, frame_ready, underflow, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT}
    function automatic logic [7:0] observed();
        if (dsel) return {lvl2, pcm2.frame_ready, uf2, b2, lr2, d2};
        return {lvl8, pcm8.frame_ready, uf8, b8, lr8, d8};
    endfunction

    // ---------------------------------------------------------------
    // One clock: advance the reference model with the current inputs,
    // clock the DUT, compare all outputs and decode the serial stream.
    // ---------------------------------------------------------------
    task automatic step(input string tag);
        int d;
        int j;
        bit pushed;
        bit m_uf;
        logic [7:0] ob;
        logic [7:0] expv;
        d      = dsel ? 2 : 8;
        fell   = 1'b0;
        pushed = 1'b0;
        m_uf   = 1'b0;
        if (rst_drv) begin
            n = 0;
            mq.delete();
            exp_q.delete();
            seen_q.delete();
            uf_q.delete();
            cur = '0; m_bclk = 0; m_lrck = 1; m_dat = 0;
            have = 0; ones = 0; fall_cnt = 0;
        end else begin
            n++;
            pushed = valid_drv && (mq.size() < DEPTH);
            if (n % (2 * d) == 0) begin
                j         = n / (2 * d);
                fall_slot = (j - 1) % 64;
                fell      = 1'b1;
                m_lrck    = (fall_slot >= 32);
                if (fall_slot == 0) begin
                    m_dat = cur[0];
                    if (mq.size() > 0) cur = mq.pop_front();
                    else begin
                        cur  = '0;
                        m_uf = 1'b1;
                    end
                    exp_q.push_back(cur);
                end else begin
                    m_dat = cur[64 - fall_slot];
                end
            end
            if (pushed) mq.push_back({left_drv, right_drv});
            m_bclk = ((n / d) % 2) == 1;
        end
        last_pushed = pushed;
        expv = {3'(mq.size()), (mq.size() != DEPTH), m_uf, m_bclk, m_lrck, m_dat};

        @(posedge CLOCK_50);
        #1;
        ob = observed();
        check(tag, ob, expv);
        if (ob[3]) uf_q.push_back(n);
        if (ob[0]) ones++;
        if (fell) begin
            fall_cnt++;
            if (fall_slot != 0) dec[64 - fall_slot] = ob[0];
            else begin
                if (have && exp_q.size() > 0) begin
                    dec[0] = ob[0];
                    check("frame", dec, exp_q.pop_front());
                    seen_q.push_back(dec);
                end
                have = 1'b1;
            end
        end
    endtask

    // ---------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------
    task automatic do_reset();
        logic [7:0] ob;
        rst_drv   = 1'b1;
        valid_drv = 1'b0;
        step("reset");
        ob = observed();
        check("rst_vec", ob, 8'b000_1_0_0_1_0);
        step("reset");
        rst_drv = 1'b0;
    endtask

    task automatic run_to(input int target, input string tag);
        while (n < target) step(tag);
    endtask

    task automatic push_frames(input int count, input int base);
        for (int k = 0; k < count; k++) begin
            valid_drv = 1'b1;
            left_drv  = 32'(base + k);
            right_drv = 32'hC0DE_0000 + 32'(k);
            step("push");
        end
        valid_drv = 1'b0;
    endtask

    // ---------------------------------------------------------------
    // Single-frame vector table: push one frame after reset, then read
    // the pin value in a given slot (64 = next frame's slot 0).
    // ---------------------------------------------------------------
    typedef struct {
        bit          sel;
        logic [31:0] l;
        logic [31:0] r;
        int          slot;
        bit          dat;
        bit          lrck;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [7:0] ob;
        int guard;
        int k;
        int found;
        bit pb;
        int pcts[4];

        tbl[0]  = '{0, 32'h8000_0001, 32'h0000_0003,  1, 1, 0};
        tbl[1]  = '{0, 32'h8000_0001, 32'h0000_0003,  2, 0, 0};
        tbl[2]  = '{0, 32'h8000_0001, 32'h0000_0003, 31, 0, 0};
        tbl[3]  = '{0, 32'h8000_0001, 32'h0000_0003, 32, 1, 1};
        tbl[4]  = '{0, 32'h8000_0001, 32'h0000_0003, 33, 0, 1};
        tbl[5]  = '{0, 32'h8000_0001, 32'h0000_0003, 62, 0, 1};
        tbl[6]  = '{0, 32'h8000_0001, 32'h0000_0003, 63, 1, 1};
        tbl[7]  = '{0, 32'h8000_0001, 32'h0000_0003, 64, 1, 0};
        tbl[8]  = '{0, 32'hA5A5_0F0F, 32'h1234_5678,  1, 1, 0};
        tbl[9]  = '{0, 32'hA5A5_0F0F, 32'h1234_5678,  2, 0, 0};
        tbl[10] = '{0, 32'hA5A5_0F0F, 32'h1234_5678,  3, 1, 0};
        tbl[11] = '{0, 32'hA5A5_0F0F, 32'h1234_5678, 32, 1, 1};
        tbl[12] = '{0, 32'hA5A5_0F0F, 32'h1234_5678, 36, 1, 1};
        tbl[13] = '{0, 32'hA5A5_0F0F, 32'h1234_5678, 60, 1, 1};
        tbl[14] = '{0, 32'hA5A5_0F0F, 32'h1234_5678, 64, 0, 0};
        tbl[15] = '{1, 32'h8000_0001, 32'h0000_0003,  1, 1, 0};
        tbl[16] = '{1, 32'h8000_0001, 32'h0000_0003,  2, 0, 0};
        tbl[17] = '{1, 32'h8000_0001, 32'h0000_0003, 32, 1, 1};
        tbl[18] = '{1, 32'h8000_0001, 32'h0000_0003, 63, 1, 1};
        tbl[19] = '{1, 32'h8000_0001, 32'h0000_0003, 64, 1, 0};

        for (int i = 0; i < 20; i++) begin
            dsel = tbl[i].sel;
            do_reset();
            left_drv  = tbl[i].l;
            right_drv = tbl[i].r;
            valid_drv = 1'b1;
            step("tbl");
            valid_drv = 1'b0;
            guard = 0;
            while (fall_cnt < tbl[i].slot + 1 && guard < 2000) begin
                step("tbl");
                guard++;
            end
            ob = observed();
            check($sformatf("tbl%0d_dat", i), ob[0], tbl[i].dat);
            check($sformatf("tbl%0d_lrck", i), ob[1], tbl[i].lrck);
        end

        // Underflow: three empty frame slots, 1024 cycles apart.
        dsel = 0;
        do_reset();
        run_to(2600, "uflow");
        check("uf_count", uf_q.size(), 3);
        check("uf_first", uf_q.size() > 0 ? uf_q[0] : -1, 16);
        check("uf_gap1", uf_q.size() > 2 ? uf_q[1] - uf_q[0] : -1, 1024);
        check("uf_gap2", uf_q.size() > 2 ? uf_q[2] - uf_q[1] : -1, 1024);
        check("uf_silent", ones, 0);

        // Backpressure: frame_valid held high with incrementing data.
        do_reset();
        k = 0;
        while (n < 5200) begin
            valid_drv = 1'b1;
            left_drv  = 32'(k);
            right_drv = 32'hC0DE_0000 + 32'(k);
            step("bp");
            if (last_pushed) k++;
            ob = observed();
            if (n == 4) begin
                check("bp_acc4", k, 4);
                check("bp_lvl4", ob[7:5], 4);
                check("bp_rdy0", ob[4], 0);
            end
            if (n == 16) check("bp_rdy16", ob[4], 1);
            if (n == 17) check("bp_lvl17", ob[7:5], 4);
        end
        valid_drv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_order%0d", i),
                  seen_q.size() > i ? {32'h0, seen_q[i][63:32]} : 64'hx, i);
        end

        // Push on the slot-0 edge with the FIFO empty.
        do_reset();
        run_to(15, "sim_e");
        valid_drv = 1'b1;
        left_drv  = 32'h1357_9BDF;
        right_drv = 32'h0246_8ACE;
        step("sim_e");
        valid_drv = 1'b0;
        ob = observed();
        check("sim_e_uf", ob[3], 1);
        check("sim_e_lvl", ob[7:5], 1);
        run_to(2070, "sim_e");
        check("sim_e_out", seen_q.size() > 1 ? seen_q[1] : 64'hx, 64'h1357_9BDF_0246_8ACE);

        // Push on the slot-0 edge with the FIFO full.
        do_reset();
        push_frames(4, 32'h40);
        run_to(15, "sim_f");
        valid_drv = 1'b1;
        left_drv  = 32'hDEAD_BEEF;
        step("sim_f");
        valid_drv = 1'b0;
        ob = observed();
        check("sim_f_lvl", ob[7:5], 3);
        check("sim_f_rdy", ob[4], 1);
        step("sim_f");
        ob = observed();
        check("sim_f_lvl2", ob[7:5], 3);

        // Reset in slot 20 with three frames buffered.
        do_reset();
        push_frames(4, 32'h80);
        run_to(340, "mid");
        ob = observed();
        check("mid_lvl", ob[7:5], 3);
        rst_drv = 1'b1;
        step("midrst");
        ob = observed();
        check("mid_rst", ob, 8'b000_1_0_0_1_0);
        rst_drv = 1'b0;
        found = -1;
        pb = 1'b0;
        for (int i = 1; i <= 40 && found < 0; i++) begin
            step("mid");
            ob = observed();
            if (pb && !ob[2]) found = i;
            pb = ob[2];
        end
        check("mid_fall", found, 16);
        check("mid_uf", ob[3], 1);

        // Random traffic against the reference model, both dividers,
        // with one reset dropped in somewhere in the middle.
        pcts = '{5, 40, 90, 100};
        for (int pass = 0; pass < 2; pass++) begin
            int cycles;
            int rst_at;
            int pct;
            dsel   = pass[0];
            do_reset();
            cycles = pass == 0 ? 8000 : 4000;
            rst_at = $urandom_range(cycles / 4, cycles / 2);
            pct    = 40;
            for (int c = 0; c < cycles; c++) begin
                if (c % 1000 == 0) pct = pcts[$urandom_range(3)];
                if (c == rst_at) begin
                    rst_drv = 1'b1;
                    step("rnd_rst");
                    rst_drv = 1'b0;
                end
                if (!valid_drv || last_pushed) begin
                    valid_drv = ($urandom_range(99) < pct);
                    left_drv  = $urandom;
                    right_drv = $urandom;
                end
                step("rnd");
            end
            valid_drv = 1'b0;
        end

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
